// File: rtl/ramp_step_decoder.sv
// Receive-side decoder for the ramp pattern generator.
// Recovers the step code (+1 / +16 / +1290) from consecutive 12-bit samples,
// locks onto a repeating step size, and reports step errors, wrap-around and
// a saturating count of steps accepted while locked.
//
// Handshake: a sample is consumed on every rising edge where dec_enb and
// sample_vld are both high. There is no back-pressure. All outputs are
// registered, so the response to a sample appears one clock later.
// dec_enb low takes priority over sample_vld and returns the block to IDLE.
module ramp_step_decoder #(
  parameter int WIDTH    = 12,
  parameter int LOCK_CNT = 4,
  parameter int ERR_MAX  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_enb,
  input  logic             sample_vld,
  input  logic [WIDTH-1:0] sample,
  output logic [1:0]       y_out,
  output logic             delta_out,
  output logic             locked,
  output logic             step_err,
  output logic             wrap,
  output logic [15:0]      step_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int AW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [1:0]       cand_q, cand_d;
  logic [AW-1:0]    acq_q, acq_d;
  logic [EW-1:0]    err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             delta_q, delta_d;
  logic             serr_q, serr_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] diff;
  logic [1:0]       code;
  logic             is_hold;
  logic             is_bad;
  logic             is_restart;
  logic             is_wrap;

  // Classify the incoming sample against the previous one (modulo 2**WIDTH).
  // A hold that lands on zero implies prev was already zero, so an encoder
  // disable only shows up as a bad step landing on zero.
  always_comb begin
    diff       = sample - prev_q;
    code       = 2'b00;
    if (diff == WIDTH'(1))         code = 2'b01;
    else if (diff == WIDTH'(16))   code = 2'b10;
    else if (diff == WIDTH'(1290)) code = 2'b11;
    is_hold    = (diff == '0);
    is_bad     = (code == 2'b00) && !is_hold;
    is_restart = (sample == '0) && is_bad;
    is_wrap    = (code != 2'b00) && (sample < prev_q);
  end

  // Next-state and next-output logic for the decoder FSM.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cand_d  = cand_q;
    acq_d   = acq_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    delta_d = 1'b0;
    serr_d  = 1'b0;
    wrap_d  = 1'b0;
    if (!dec_enb) begin
      state_d = IDLE;
      prev_d  = '0;
      cand_d  = 2'b00;
      acq_d   = '0;
      err_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = FIRST;
        FIRST: begin
          if (sample_vld) begin
            prev_d  = sample;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (sample_vld) begin
            prev_d = sample;
            if (is_restart) begin
              cand_d = 2'b00;
              acq_d  = '0;
              err_d  = '0;
            end else if (code != 2'b00) begin
              delta_d = 1'b1;
              wrap_d  = is_wrap;
              cand_d  = code;
              if (code == cand_q) acq_d = acq_q + AW'(1);
              else                acq_d = AW'(1);
              if (acq_d == AW'(LOCK_CNT)) begin
                state_d = LOCKED;
                err_d   = '0;
              end
            end else if (is_bad) begin
              acq_d = '0;
            end
          end
        end
        LOCKED: begin
          if (sample_vld) begin
            prev_d = sample;
            if (is_restart) begin
              state_d = ACQUIRE;
              cand_d  = 2'b00;
              acq_d   = '0;
              err_d   = '0;
            end else if (!is_hold) begin
              if (code == cand_q) begin
                delta_d = 1'b1;
                wrap_d  = is_wrap;
                err_d   = '0;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
              end else begin
                serr_d = 1'b1;
                wrap_d = is_wrap;
                if (err_q == EW'(ERR_MAX - 1)) begin
                  state_d = ACQUIRE;
                  acq_d   = '0;
                  err_d   = '0;
                end else begin
                  err_d = err_q + EW'(1);
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cand_q  <= 2'b00;
      acq_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      delta_q <= 1'b0;
      serr_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cand_q  <= cand_d;
      acq_q   <= acq_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      delta_q <= delta_d;
      serr_q  <= serr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y_out     = cand_q;
  assign delta_out = delta_q;
  assign locked    = (state_q == LOCKED);
  assign step_err  = serr_q;
  assign wrap      = wrap_q;
  assign step_cnt  = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ramp_step_decoder.sv
// Bench for ramp_step_decoder: directed scenarios followed by random samples,
// every cycle compared against a behavioural model of the decoder rules.
module tb_ramp_step_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_enb = 1'b0;
  logic        sample_vld = 1'b0;
  logic [11:0] sample = '0;
  logic [1:0]  y_out;
  logic        delta_out, locked, step_err, wrap;
  logic [15:0] step_cnt;
  logic [1:0]  state_dbg;

  ramp_step_decoder dut (
    .clk(clk), .rst(rst), .dec_enb(dec_enb), .sample_vld(sample_vld),
    .sample(sample), .y_out(y_out), .delta_out(delta_out), .locked(locked),
    .step_err(step_err), .wrap(wrap), .step_cnt(step_cnt), .state_dbg(state_dbg)
  );

  // Clock and counters
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = disabled, 1 = waiting for first sample, 2 = tracking
  int m_mode, m_prev, m_cand, m_run, m_errs, m_cnt;
  bit m_locked;
  int e_y, e_cnt;
  bit e_d, e_err, e_wr;
  int step_tab[3] = '{1, 16, 1290};

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_cand = 0; m_run = 0; m_errs = 0; m_cnt = 0;
    m_locked = 0; e_y = 0; e_cnt = 0; e_d = 0; e_err = 0; e_wr = 0;
  endtask

  task automatic model_step(input bit enb, input bit vld, input int s);
    int d, c;
    e_d = 0; e_err = 0; e_wr = 0;
    if (!enb) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    if (!vld) return;
    if (m_mode == 1) begin
      m_prev = s;
      m_mode = 2;
      return;
    end
    d = (s - m_prev + 4096) % 4096;
    c = 0;
    for (int i = 0; i < 3; i++) if (d == step_tab[i]) c = i + 1;
    if (d == 0) begin
      // hold: nothing moves
    end else if (c == 0 && s == 0) begin
      m_locked = 0; m_cand = 0; m_run = 0; m_errs = 0;
    end else if (!m_locked) begin
      if (c == 0) m_run = 0;
      else begin
        e_d = 1;
        e_wr = (s < m_prev);
        m_run = (c == m_cand) ? m_run + 1 : 1;
        m_cand = c;
        if (m_run == 4) begin m_locked = 1; m_errs = 0; end
      end
    end else if (c == m_cand) begin
      e_d = 1;
      e_wr = (s < m_prev);
      m_errs = 0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      e_err = 1;
      e_wr = (c != 0) && (s < m_prev);
      m_errs++;
      if (m_errs == 2) begin m_locked = 0; m_run = 0; m_errs = 0; end
    end
    m_prev = s;
    e_y = m_cand;
    e_cnt = m_cnt;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("y_out",     16'(y_out),     16'(e_y));
    check("delta_out", 16'(delta_out), 16'(e_d));
    check("locked",    16'(locked),    16'(m_locked));
    check("step_err",  16'(step_err),  16'(e_err));
    check("wrap",      16'(wrap),      16'(e_wr));
    check("step_cnt",  step_cnt,       16'(e_cnt));
  endtask

  // Driver: one clock with given inputs, model update, check at the falling edge
  task automatic cyc(input bit enb, input bit vld, input int s);
    dec_enb = enb; sample_vld = vld; sample = 12'(s);
    @(posedge clk);
    model_step(enb, vld, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic feed(input int s);
    cyc(1, 1, s);
  endtask

  int pulses;
  int last_s, fav, r, s_next;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_locked", 16'(locked), 16'd0);
    rst = 1'b1;

    // +1 ramp locks after four steps
    cyc(1, 0, 0);
    feed(0);
    pulses = 0;
    for (int v = 1; v <= 4; v++) begin
      feed(v);
      pulses += int'(delta_out);
    end
    check("t2_pulses", 16'(pulses), 16'd4);
    check("t2_locked", 16'(locked), 16'd1);
    check("t2_y", 16'(y_out), 16'd1);

    // +1290 ramp with wrap on the locking step
    feed(0);
    check("t3_restart_locked", 16'(locked), 16'd0);
    check("t3_restart_y", 16'(y_out), 16'd0);
    feed(1290); feed(2580); feed(3870);
    check("t3_not_yet", 16'(locked), 16'd0);
    feed(1064);
    check("t3_locked", 16'(locked), 16'd1);
    check("t3_wrap", 16'(wrap), 16'd1);
    check("t3_y", 16'(y_out), 16'd3);

    // +16 lock at 48, holds ignored, 64 counted
    feed(0); feed(4080); feed(0); feed(16); feed(32); feed(48);
    check("t4_locked", 16'(locked), 16'd1);
    check("t4_y", 16'(y_out), 16'd2);
    feed(48);
    check("t4_hold_delta", 16'(delta_out | step_err), 16'd0);
    feed(48);
    check("t4_hold_cnt", step_cnt, 16'd0);
    feed(64);
    check("t4_cnt", step_cnt, 16'd1);

    // error handling and relock on +1
    feed(0); feed(6); feed(7); feed(8); feed(9); feed(10);
    check("t5_locked", 16'(locked), 16'd1);
    feed(13);
    check("t5_err1", 16'(step_err), 16'd1);
    check("t5_still_locked", 16'(locked), 16'd1);
    feed(20);
    check("t5_err2", 16'(step_err), 16'd1);
    check("t5_dropped", 16'(locked), 16'd0);
    check("t5_y_kept", 16'(y_out), 16'd1);
    feed(21); feed(22); feed(23);
    check("t5_relock_wait", 16'(locked), 16'd0);
    feed(24);
    check("t5_relocked", 16'(locked), 16'd1);

    // restart on zero, then disable clears step_cnt
    feed(0);
    for (int v = 996; v <= 1000; v++) feed(v);
    check("t6_locked", 16'(locked), 16'd1);
    feed(1001);
    check("t6_cnt", step_cnt, 16'd2);
    feed(0);
    check("t6_restart", 16'(locked), 16'd0);
    check("t6_y", 16'(y_out), 16'd0);
    check("t6_noerr", 16'(step_err), 16'd0);
    cyc(0, 0, 0);
    check("t6_cnt_clr", step_cnt, 16'd0);

    // async reset in the middle of a lock
    cyc(1, 0, 0);
    for (int v = 500; v <= 505; v++) feed(v);
    check("t1_pre_locked", 16'(locked), 16'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t1_async_cnt", step_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int v = 0; v < 4; v++) cyc(0, 1, v);
    cyc(1, 0, 0);
    feed(7);
    check("t1_first_nodelta", 16'(delta_out), 16'd0);
    feed(8);
    check("t1_after", 16'(delta_out), 16'd1);

    // random stimulus
    last_s = 8;
    fav = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 60) == 0) fav = $urandom_range(0, 2);
      if (r < 55)      s_next = (last_s + step_tab[fav]) % 4096;
      else if (r < 63) s_next = (last_s + step_tab[$urandom_range(0, 2)]) % 4096;
      else if (r < 73) s_next = last_s;
      else if (r < 81) s_next = $urandom_range(0, 4095);
      else if (r < 85) s_next = 0;
      else             s_next = (last_s + step_tab[fav]) % 4096;
      if ($urandom_range(0, 99) < 2) begin
        cyc(0, $urandom_range(0, 1), s_next);
      end else if ($urandom_range(0, 99) < 80) begin
        feed(s_next);
        last_s = s_next;
      end else begin
        cyc(1, 0, $urandom_range(0, 4095));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
